// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory bus that the arbiter sits between.
// slave is the arbiter's view; master is the requesters-plus-memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_done;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  d_req;
  logic [1:0]            d_access;
  logic [2:0]            d_size;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  err;

  logic                  mem_req;
  logic                  mem_write;
  logic [2:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_access, d_size, d_addr, d_wdata,
           mem_ack, mem_rvalid, mem_rdata,
    output f_done, f_rdata, d_done, d_rdata, err,
           mem_req, mem_write, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_access, d_size, d_addr, d_wdata,
           mem_ack, mem_rvalid, mem_rdata,
    input  f_done, f_rdata, d_done, d_rdata, err,
           mem_req, mem_write, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one transaction outstanding, with a response timeout that aborts a dead memory access.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] MEM_NO_ACCESS = 2'd0;
  localparam logic [1:0] MEM_WRITE     = 2'd2;
  localparam logic [2:0] MEM_WORD      = 3'd2;
  localparam int         CNT_W         = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = data path owns the bus
  logic                  last_q, last_d;     // 1 = data was granted last
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic d_valid;
  logic grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    d_valid = bus.d_req && (bus.d_access != MEM_NO_ACCESS);
    // Data wins when alone, or when both ask and fetch was served last.
    grant_d = d_valid && (!bus.f_req || !last_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.f_req || d_valid) begin
          owner_d = grant_d;
          last_d  = grant_d;
          state_d = S_REQ;
          if (grant_d) begin
            addr_d  = bus.d_addr;
            size_d  = bus.d_size;
            write_d = (bus.d_access == MEM_WRITE);
            wdata_d = (bus.d_access == MEM_WRITE) ? bus.d_wdata : '0;
          end else begin
            addr_d  = bus.f_addr;
            size_d  = MEM_WORD;
            write_d = 1'b0;
            wdata_d = '0;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_rvalid) begin
          rdata_d = write_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_write = write_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.f_done    = (state_q == S_DONE) && !owner_q;
  assign bus.d_done    = (state_q == S_DONE) && owner_q;
  assign bus.err       = (state_q == S_DONE) && err_q;
  assign bus.f_rdata   = bus.f_done ? rdata_q : '0;
  assign bus.d_rdata   = bus.d_done ? rdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand sequences
// for arbitration order, response timeout and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
  localparam logic [1:0] ACC_NO = 2'd0, ACC_RD = 2'd1, ACC_WR = 2'd2;
  localparam logic [2:0] SZ_BYTE = 3'd0, SZ_WORD = 3'd2, SZ_DOUBLE = 3'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        fr;  logic [63:0] fa;
    logic        dr;  logic [1:0] dacc; logic [2:0] dsz; logic [63:0] da; logic [63:0] dwd;
    logic        ack; logic rv; logic [63:0] rd;
    logic        chk;
    logic        e_req; logic e_wr; logic [2:0] e_sz; logic [63:0] e_addr; logic [63:0] e_wd;
    logic        e_fd; logic e_dd; logic e_err; logic [63:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fr, input logic [63:0] fa, input logic dr, input logic [1:0] dacc,
                     input logic [2:0] dsz, input logic [63:0] da, input logic [63:0] dwd,
                     input logic ack, input logic rv, input logic [63:0] rd, input logic chk_bus,
                     input logic e_req, input logic e_wr, input logic [2:0] e_sz,
                     input logic [63:0] e_addr, input logic [63:0] e_wd,
                     input logic e_fd, input logic e_dd, input logic e_err, input logic [63:0] e_rd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.dr = dr; v.dacc = dacc; v.dsz = dsz; v.da = da; v.dwd = dwd;
    v.ack = ack; v.rv = rv; v.rd = rd; v.chk = chk_bus;
    v.e_req = e_req; v.e_wr = e_wr; v.e_sz = e_sz; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_fd = e_fd; v.e_dd = e_dd; v.e_err = e_err; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_access = ACC_NO; bus.d_size = '0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
  endtask

  // Waits for mem_req, acks it, returns rdata next cycle and samples the DONE cycle.
  task automatic txn(input logic [63:0] rdata, output logic got_f, output logic got_d,
                     output logic [63:0] addr, output logic [2:0] size,
                     output logic [63:0] rd, output logic e);
    int n = 0;
    got_f = 0; got_d = 0; addr = '0; size = '0; rd = '0; e = 0;
    while (!bus.mem_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.mem_req) begin
      chk("txn wait mem_req", 64'(bus.mem_req), 64'd1);
      return;
    end
    addr = bus.mem_addr;
    size = bus.mem_size;
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    bus.mem_rvalid = 1;
    bus.mem_rdata = rdata;
    step();
    bus.mem_rvalid = 0;
    got_f = bus.f_done;
    got_d = bus.d_done;
    rd = bus.f_done ? bus.f_rdata : bus.d_rdata;
    e = bus.err;
  endtask

  logic        gf, gd, ge;
  logic [63:0] ga, grd;
  logic [2:0]  gs;
  int          wcnt;

  initial begin
    drive_idle();
    step();
    chk("reset mem_req", 64'(bus.mem_req), 64'd0);
    chk("reset mem_addr", bus.mem_addr, 64'd0);
    chk("reset done/err", {61'd0, bus.f_done, bus.d_done, bus.err}, 64'd0);
    step();
    reset = 0;

    // fetch, zero-wait memory
    add(1,'h1000, 0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            0,0,0,0);
    add(1,'h1000, 0,ACC_NO,0,0,0, 1,0,0,     1, 1,0,SZ_WORD,'h1000,0, 0,0,0,0);
    add(1,'h1000, 0,ACC_NO,0,0,0, 0,1,'h13,  1, 0,0,SZ_WORD,'h1000,0, 0,0,0,0);
    add(1,'h1000, 0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            1,0,0,'h13);
    add(0,0,      0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            0,0,0,0);
    // byte store, ack delayed one cycle; read data on a write is discarded
    add(0,0, 1,ACC_WR,SZ_BYTE,'h3003,'hAB, 0,0,0,      0, 0,0,0,0,0,                   0,0,0,0);
    add(0,0, 1,ACC_WR,SZ_BYTE,'h3003,'hAB, 0,0,0,      1, 1,1,SZ_BYTE,'h3003,'hAB,     0,0,0,0);
    add(0,0, 1,ACC_WR,SZ_BYTE,'h3003,'hAB, 1,0,0,      1, 1,1,SZ_BYTE,'h3003,'hAB,     0,0,0,0);
    add(0,0, 1,ACC_WR,SZ_BYTE,'h3003,'hAB, 0,1,'hDEAD, 1, 0,1,SZ_BYTE,'h3003,'hAB,     0,0,0,0);
    add(0,0, 1,ACC_WR,SZ_BYTE,'h3003,'hAB, 0,0,0,      0, 0,0,0,0,0,                   0,1,0,0);
    add(0,0, 0,ACC_NO,0,0,0,               0,0,0,      0, 0,0,0,0,0,                   0,0,0,0);
    // MEM_NO_ACCESS is never granted; stray ack/rvalid in IDLE are ignored
    for (int i = 0; i < 10; i++)
      add(0,0, 1,ACC_NO,SZ_WORD,'h5000,'h11, logic'(i % 3 == 0), logic'(i % 2), 'h99,
          0, 0,0,0,0,0, 0,0,0,0);
    // ack and rvalid together in REQ count as ack only
    add(1,'h1008, 0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            0,0,0,0);
    add(1,'h1008, 0,ACC_NO,0,0,0, 1,1,'h55,  1, 1,0,SZ_WORD,'h1008,0, 0,0,0,0);
    add(1,'h1008, 0,ACC_NO,0,0,0, 0,0,0,     1, 0,0,SZ_WORD,'h1008,0, 0,0,0,0);
    add(1,'h1008, 0,ACC_NO,0,0,0, 0,1,'h77,  1, 0,0,SZ_WORD,'h1008,0, 0,0,0,0);
    add(1,'h1008, 0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            1,0,0,'h77);
    add(0,0,      0,ACC_NO,0,0,0, 0,0,0,     0, 0,0,0,0,0,            0,0,0,0);

    foreach (vecs[i]) begin
      bus.f_req = vecs[i].fr; bus.f_addr = vecs[i].fa;
      bus.d_req = vecs[i].dr; bus.d_access = vecs[i].dacc; bus.d_size = vecs[i].dsz;
      bus.d_addr = vecs[i].da; bus.d_wdata = vecs[i].dwd;
      bus.mem_ack = vecs[i].ack; bus.mem_rvalid = vecs[i].rv; bus.mem_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d mem_req", i), 64'(bus.mem_req), 64'(vecs[i].e_req));
      chk($sformatf("v%0d f_done", i), 64'(bus.f_done), 64'(vecs[i].e_fd));
      chk($sformatf("v%0d d_done", i), 64'(bus.d_done), 64'(vecs[i].e_dd));
      chk($sformatf("v%0d err", i), 64'(bus.err), 64'(vecs[i].e_err));
      if (vecs[i].e_fd) chk($sformatf("v%0d f_rdata", i), bus.f_rdata, vecs[i].e_rd);
      if (vecs[i].e_dd) chk($sformatf("v%0d d_rdata", i), bus.d_rdata, vecs[i].e_rd);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d mem_write", i), 64'(bus.mem_write), 64'(vecs[i].e_wr));
        chk($sformatf("v%0d mem_size", i), 64'(bus.mem_size), 64'(vecs[i].e_sz));
        chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_wd);
      end
      @(posedge clk);
      #1;
    end
    drive_idle();

    // Arbitration after reset: data first, then fetch, then data again
    reset = 1; step(); reset = 0;
    bus.f_req = 1; bus.f_addr = 'h1100;
    bus.d_req = 1; bus.d_access = ACC_RD; bus.d_size = SZ_DOUBLE; bus.d_addr = 'h2000;
    txn('hD1, gf, gd, ga, gs, grd, ge);
    chk("arb1 owner", {62'd0, gf, gd}, 64'b01);
    chk("arb1 addr", ga, 64'h2000);
    chk("arb1 size", 64'(gs), 64'(SZ_DOUBLE));
    chk("arb1 rdata", grd, 64'hD1);
    txn('hF1, gf, gd, ga, gs, grd, ge);
    chk("arb2 owner", {62'd0, gf, gd}, 64'b10);
    chk("arb2 addr", ga, 64'h1100);
    chk("arb2 size", 64'(gs), 64'(SZ_WORD));
    chk("arb2 rdata", grd, 64'hF1);
    bus.f_req = 0; bus.d_req = 0;
    step();
    chk("arb gap mem_req", 64'(bus.mem_req), 64'd0);
    bus.f_req = 1; bus.d_req = 1;
    txn('hD2, gf, gd, ga, gs, grd, ge);
    chk("arb3 owner", {62'd0, gf, gd}, 64'b01);
    chk("arb3 addr", ga, 64'h2000);

    // Timeout: data acked, no rvalid; fetch waits behind it
    bus.f_req = 0; bus.d_req = 0;
    step();
    bus.d_req = 1; bus.d_access = ACC_RD; bus.d_size = SZ_WORD; bus.d_addr = 'h4000;
    wcnt = 0;
    while (!bus.mem_req && wcnt < 20) begin step(); wcnt++; end
    chk("to mem_req", 64'(bus.mem_req), 64'd1);
    chk("to addr", bus.mem_addr, 64'h4000);
    bus.f_req = 1; bus.f_addr = 'h1200;
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk($sformatf("to early done k=%0d", k), {62'd0, bus.f_done, bus.d_done}, 64'd0);
    end
    chk("to d_done", 64'(bus.d_done), 64'd1);
    chk("to err", 64'(bus.err), 64'd1);
    chk("to d_rdata", bus.d_rdata, 64'd0);
    bus.d_req = 0;
    txn('hF2, gf, gd, ga, gs, grd, ge);
    chk("after to owner", {62'd0, gf, gd}, 64'b10);
    chk("after to addr", ga, 64'h1200);
    chk("after to rdata", grd, 64'hF2);
    chk("after to err", 64'(ge), 64'd0);

    // Asynchronous reset during WAIT
    bus.f_req = 0;
    step();
    bus.f_req = 1; bus.f_addr = 'h1300;
    wcnt = 0;
    while (!bus.mem_req && wcnt < 20) begin step(); wcnt++; end
    chk("rst mem_req", 64'(bus.mem_req), 64'd1);
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    #2 reset = 1;
    #1;
    chk("rst async mem_addr", bus.mem_addr, 64'd0);
    chk("rst async mem_size", 64'(bus.mem_size), 64'd0);
    chk("rst async flags", {59'd0, bus.mem_req, bus.mem_write, bus.f_done, bus.d_done, bus.err}, 64'd0);
    bus.f_req = 0;
    step(); step();
    reset = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 'hBAD;
    step();
    bus.mem_rvalid = 0;
    chk("stale rvalid", {61'd0, bus.mem_req, bus.f_done, bus.d_done}, 64'd0);
    bus.f_req = 1; bus.f_addr = 'h1400;
    txn('hF4, gf, gd, ga, gs, grd, ge);
    chk("post rst owner", {62'd0, gf, gd}, 64'b10);
    chk("post rst addr", ga, 64'h1400);
    chk("post rst rdata", grd, 64'hF4);
    bus.f_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between instruction fetch and the load/store path driven by the decoder's mem_access/mem_size outputs.
Uses round-robin arbitration, keeps one transaction outstanding, and latches every request.
Enforces a response timeout so a dead memory cannot hang the core.
Sits between fetch, the memory stage and the memory bus interface.

Parameters:
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 64, read/write data width
TIMEOUT, 255, max cycles from mem_ack to mem_rvalid before abort (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch request, held until f_done
f_addr  in  ADDR_WIDTH  fetch address (read, MEM_WORD)
f_done  out  1  one-cycle pulse: fetch transaction finished
f_rdata  out  DATA_WIDTH  fetch data, valid with f_done
d_req  in  1  data request, held until d_done
d_access  in  2  MEM_NO_ACCESS / MEM_READ / MEM_WRITE (Mem.defs)
d_size  in  3  Mem.defs size code (MEM_BYTE..MEM_US_WORD)
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_done  out  1  one-cycle pulse: data transaction finished
d_rdata  out  DATA_WIDTH  load data, valid with d_done
err  out  1  one-cycle pulse with f_done/d_done when the transaction timed out
mem_req  out  1  bus request, held until mem_ack
mem_write  out  1  1 = write
mem_size  out  3  size code forwarded from requester (MEM_WORD for fetch)
mem_addr  out  ADDR_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched store data (0 for reads)
mem_ack  in  1  bus accepted request (sampled only while mem_req=1)
mem_rvalid  in  1  response/completion strobe (writes also complete with it)
mem_rdata  in  DATA_WIDTH  read data, valid with mem_rvalid

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=FETCH; timeout counter 0. Reset mid-transaction aborts it, with no done pulse.
- Effective data request: d_req=1 and d_access!=MEM_NO_ACCESS. MEM_NO_ACCESS with d_req=1 is never granted.
- States:
  - IDLE: pick a requester, latch its address/size/write/wdata into output registers, set owner, go to REQ. Nothing pending -> stay.
  - REQ: mem_req=1, outputs stable. mem_ack=1 -> counter cleared, go to WAIT.
  - WAIT: mem_req=0, counter increments each cycle.
    - mem_rvalid=1 -> owner's done=1 next cycle, rdata=mem_rdata (0 for writes), go to DONE.
    - counter==TIMEOUT without rvalid -> done=1, err=1, rdata=0, go to DONE.
  - DONE: done/err are high this single cycle, then IDLE.
- No arbitration in DONE, so a requester can drop its req after done before re-arbitration.
- Arbitration: if only one requester is valid, grant it. If both are valid, grant the one not equal to last_grant. last_grant updates on grant.
  - First simultaneous request after reset goes to data.
  - Alternation guarantees neither starves.
- Latency with zero-wait memory (mem_ack in the first REQ cycle, mem_rvalid the next cycle): request seen in IDLE at cycle 0 -> mem_req cycle 1 -> rvalid cycle 2 -> done cycle 3. Minimum 4 cycles per transaction.
- Requester inputs change during a transaction: ignored, the latched values are used.
- mem_rvalid outside WAIT: ignored. mem_ack outside REQ: ignored.
- mem_ack and mem_rvalid high in the same REQ cycle: treated as ack only. The response must arrive in WAIT.
- Timeout counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- f_done and d_done are never high in the same cycle.

Test Plan:
- Reset, then f_req=1, f_addr=0x1000, mem_ack in the 1st REQ cycle, rvalid next cycle with rdata=0x00000013 -> mem_req at cycle 1 with mem_addr=0x1000, mem_write=0, mem_size=MEM_WORD; f_done=1, f_rdata=0x13 at cycle 3.
- After reset, f_req and d_req (MEM_READ, MEM_DOUBLE, 0x2000) rise together, both held -> data granted first, fetch second; both requests re-asserted -> data again only after the fetch completes.
- d_req with d_access=MEM_WRITE, MEM_BYTE, addr 0x3003, wdata 0xAB -> mem_write=1, mem_size=MEM_BYTE, mem_wdata=0xAB; d_done pulses with d_rdata=0.
- d_req=1 with d_access=MEM_NO_ACCESS and f_req=0 held 10 cycles -> mem_req stays 0, no done.
- TIMEOUT=4, memory acks but never rvalids -> d_done=1 and err=1 together, 4 cycles after entering WAIT; arbiter then serves a pending fetch normally.
- Reset asserted asynchronously during WAIT -> all outputs 0 immediately. After release, a fresh f_req completes normally and the stale rvalid is ignored.
